// File: rtl/gcd_job_issuer.sv
// gcd_job_issuer: takes operand pairs from an upstream valid/ready port,
// starts an external GCD core with a one-cycle go pulse, waits for its
// done flag and presents the result on a downstream valid/ready port.
// Zero operands are rejected without starting the core.
// Optional watchdog: define GCD_JOB_ISSUER_TIMEOUT_EN to abandon a job
// after TIMEOUT_CYCLES cycles in WAIT without done.
//
// state  | meaning
// IDLE   | ready for a new operand pair
// GO     | single-cycle start pulse to the core
// SETTLE | core may still show the previous job's done; ignore it
// WAIT   | sampling done (and the watchdog, when built in)
// RESP   | result held on the downstream port until res_ready
module gcd_job_issuer #(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             go,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  input  logic             done,
  input  logic [WIDTH-1:0] out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_x,
  output logic [WIDTH-1:0] res_y,
  output logic [WIDTH-1:0] res_gcd,
  output logic             res_err,
  output logic             res_timeout,
  output logic [15:0]      job_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GO     = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]       state;
  logic [WIDTH-1:0] op_x;
  logic [WIDTH-1:0] op_y;
  logic [WIDTH-1:0] gcd_q;
  logic             err_q;
  logic             accept;
  logic             zero_op;
  logic             wd_hit;

  // in_ready is gated by rst so the block never looks ready while held in reset.
  assign in_ready  = (state == S_IDLE) && rst;
  assign accept    = in_valid && in_ready;
  assign zero_op   = (in_x == '0) || (in_y == '0);
  assign go        = (state == S_GO);
  assign res_valid = (state == S_RESP);
  assign x         = op_x;
  assign y         = op_y;
  assign res_x     = op_x;
  assign res_y     = op_y;
  assign res_gcd   = gcd_q;
  assign res_err   = err_q;

  // Main sequencer: operand latch, state transitions and result capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      op_x  <= '0;
      op_y  <= '0;
      gcd_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_x <= in_x;
            op_y <= in_y;
            if (zero_op) begin
              gcd_q <= '0;
              err_q <= 1'b1;
              state <= S_RESP;
            end else begin
              state <= S_GO;
            end
          end
        end
        S_GO:     state <= S_SETTLE;
        S_SETTLE: state <= S_WAIT;
        S_WAIT: begin
          // done takes priority over a watchdog expiry on the same cycle
          if (done) begin
            gcd_q <= out;
            err_q <= 1'b0;
            state <= S_RESP;
          end else if (wd_hit) begin
            gcd_q <= '0;
            err_q <= 1'b0;
            state <= S_RESP;
          end
        end
        S_RESP: begin
          if (res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Completed-result counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) job_count <= 16'd0;
    else if ((state == S_RESP) && res_ready) job_count <= job_count + 16'd1;
  end

`ifdef GCD_JOB_ISSUER_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            tmo_q;

  // Watchdog counts WAIT cycles; cleared in SETTLE so each job starts at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wd_cnt <= '0;
    else if (state == S_SETTLE) wd_cnt <= '0;
    else if (state == S_WAIT) wd_cnt <= wd_cnt + WD_W'(1);
  end

  assign wd_hit = (state == S_WAIT) && !done && (wd_cnt == WD_LAST);

  // Timeout flag: set on expiry, cleared by a normal completion or a new accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tmo_q <= 1'b0;
    else if (accept) tmo_q <= 1'b0;
    else if ((state == S_WAIT) && done) tmo_q <= 1'b0;
    else if (wd_hit) tmo_q <= 1'b1;
  end

  assign res_timeout = tmo_q;
`else
  assign wd_hit      = 1'b0;
  assign res_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_job_issuer.sv
// Directed bench for gcd_job_issuer. The GCD core is played by the bench:
// done/out are driven by hand with precomputed GCD values.
module tb_gcd_job_issuer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [7:0] in_x, in_y;
  logic       go;
  logic [7:0] x, y;
  logic       done;
  logic [7:0] out;
  logic       res_valid, res_ready;
  logic [7:0] res_x, res_y, res_gcd;
  logic       res_err, res_timeout;
  logic [15:0] job_count;

  int vectors = 0;
  int miscompares = 0;
  int exp_jobs = 0;

  gcd_job_issuer #(.WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .go(go), .x(x), .y(y), .done(done), .out(out),
    .res_valid(res_valid), .res_ready(res_ready), .res_x(res_x), .res_y(res_y),
    .res_gcd(res_gcd), .res_err(res_err), .res_timeout(res_timeout),
    .job_count(job_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    exp_jobs++;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0;
    done = 1'b0; out = '0; res_ready = 1'b0;
    step();
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    vectors++; if (go !== 1'b0) begin miscompares++; $display("FAIL reset_go: got %b expected 0", go); end
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
    vectors++; if ({x, y, res_gcd} !== 24'd0) begin miscompares++; $display("FAIL reset_data: got x=%0d y=%0d gcd=%0d expected 0", x, y, res_gcd); end
    vectors++; if ({res_err, res_timeout} !== 2'b00) begin miscompares++; $display("FAIL reset_flags: got %b expected 00", {res_err, res_timeout}); end
    vectors++; if (job_count !== 16'd0) begin miscompares++; $display("FAIL reset_job_count: got %0d expected 0", job_count); end
    step();
    rst = 1'b1;
    step();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_idle_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    int gos; int lat; bit unstable;
    gos = 0; lat = -1; unstable = 1'b0;
    in_valid = 1'b1; in_x = 8'd12; in_y = 8'd18;
    step();
    in_valid = 1'b0; in_x = '0; in_y = '0;
    vectors++; if (go !== 1'b1) begin miscompares++; $display("FAIL basic_go_after_accept: got %b expected 1", go); end
    if (go === 1'b1) gos++;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      step();
      if (go === 1'b1) gos++;
      if (x !== 8'd12 || y !== 8'd18) unstable = 1'b1;
      if (res_valid === 1'b1) lat = i;
      else if (i == 5) begin done = 1'b1; out = 8'd6; end
    end
    done = 1'b0; out = '0;
    vectors++; if (gos != 1) begin miscompares++; $display("FAIL basic_go_pulses: got %0d expected 1", gos); end
    vectors++; if (lat != 6) begin miscompares++; $display("FAIL basic_latency: got %0d expected 6", lat); end
    vectors++; if (unstable) begin miscompares++; $display("FAIL basic_xy_stable: got unstable expected x=12 y=18"); end
    vectors++; if (res_gcd !== 8'd6) begin miscompares++; $display("FAIL basic_gcd: got %0d expected 6", res_gcd); end
    vectors++; if ({res_err, res_timeout} !== 2'b00) begin miscompares++; $display("FAIL basic_flags: got %b expected 00", {res_err, res_timeout}); end
    vectors++; if (res_x !== 8'd12 || res_y !== 8'd18) begin miscompares++; $display("FAIL basic_res_xy: got %0d,%0d expected 12,18", res_x, res_y); end
    release_result();
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL basic_release: got %b expected 0", res_valid); end
    vectors++; if (job_count !== 16'(exp_jobs)) begin miscompares++; $display("FAIL basic_job_count: got %0d expected %0d", job_count, exp_jobs); end
  endtask

  task automatic test_stale_done();
    done = 1'b1; out = 8'd99;
    in_valid = 1'b1; in_x = 8'd9; in_y = 8'd6;
    step();
    in_valid = 1'b0;
    step();
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL stale_in_settle: got res_valid=%b expected 0", res_valid); end
    step();
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL stale_in_wait: got res_valid=%b expected 0", res_valid); end
    done = 1'b0; out = '0;
    step(); step();
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL stale_no_done: got res_valid=%b expected 0", res_valid); end
    done = 1'b1; out = 8'd3;
    step();
    done = 1'b0; out = '0;
    vectors++; if (res_valid !== 1'b1 || res_gcd !== 8'd3) begin miscompares++; $display("FAIL stale_result: got valid=%b gcd=%0d expected 1,3", res_valid, res_gcd); end
    release_result();
    vectors++; if (job_count !== 16'(exp_jobs)) begin miscompares++; $display("FAIL stale_job_count: got %0d expected %0d", job_count, exp_jobs); end
  endtask

  task automatic test_zero_operand();
    in_valid = 1'b1; in_x = 8'd0; in_y = 8'd7;
    step();
    in_valid = 1'b0;
    vectors++; if (go !== 1'b0) begin miscompares++; $display("FAIL zero_go: got %b expected 0", go); end
    vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL zero_res_valid: got %b expected 1", res_valid); end
    vectors++; if ({res_err, res_timeout} !== 2'b10 || res_gcd !== 8'd0) begin miscompares++; $display("FAIL zero_result: got err=%b tmo=%b gcd=%0d expected 1,0,0", res_err, res_timeout, res_gcd); end
    release_result();
    in_valid = 1'b1; in_x = 8'd5; in_y = 8'd0;
    step();
    in_valid = 1'b0;
    vectors++; if (res_valid !== 1'b1 || res_err !== 1'b1 || go !== 1'b0) begin miscompares++; $display("FAIL zero_y: got valid=%b err=%b go=%b expected 1,1,0", res_valid, res_err, go); end
    release_result();
    vectors++; if (job_count !== 16'(exp_jobs)) begin miscompares++; $display("FAIL zero_job_count: got %0d expected %0d", job_count, exp_jobs); end
  endtask

  task automatic test_back_pressure();
    bit broken;
    broken = 1'b0;
    in_valid = 1'b1; in_x = 8'd10; in_y = 8'd15;
    step();
    in_valid = 1'b0;
    step(); step();
    done = 1'b1; out = 8'd5;
    step();
    done = 1'b0; out = '0;
    vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL bp_min_latency: got res_valid=%b expected 1", res_valid); end
    in_valid = 1'b1; in_x = 8'd1; in_y = 8'd1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (res_valid !== 1'b1 || res_gcd !== 8'd5 || res_x !== 8'd10 || res_y !== 8'd15 ||
          res_err !== 1'b0 || res_timeout !== 1'b0 || in_ready !== 1'b0) broken = 1'b1;
    end
    in_valid = 1'b0;
    vectors++; if (broken) begin miscompares++; $display("FAIL bp_hold: got result disturbed expected gcd=5 held, in_ready=0"); end
    release_result();
    vectors++; if (res_valid !== 1'b0 || job_count !== 16'(exp_jobs)) begin miscompares++; $display("FAIL bp_transfer: got valid=%b count=%0d expected 0,%0d", res_valid, job_count, exp_jobs); end
    step();
    vectors++; if (job_count !== 16'(exp_jobs) || in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_single_transfer: got count=%0d ready=%b expected %0d,1", job_count, in_ready, exp_jobs); end
  endtask

  task automatic test_timeout();
    int lat;
`ifdef GCD_JOB_ISSUER_TIMEOUT_EN
    lat = -1;
    in_valid = 1'b1; in_x = 8'd20; in_y = 8'd30;
    step();
    in_valid = 1'b0;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      step();
      if (res_valid === 1'b1) lat = i;
    end
    vectors++; if (lat != 18) begin miscompares++; $display("FAIL tmo_latency: got %0d expected 18", lat); end
    vectors++; if ({res_err, res_timeout} !== 2'b01 || res_gcd !== 8'd0) begin miscompares++; $display("FAIL tmo_result: got err=%b tmo=%b gcd=%0d expected 0,1,0", res_err, res_timeout, res_gcd); end
    release_result();
    lat = -1;
    in_valid = 1'b1; in_x = 8'd14; in_y = 8'd21;
    step();
    in_valid = 1'b0;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      step();
      if (res_valid === 1'b1) lat = i;
      else if (i == 17) begin done = 1'b1; out = 8'd7; end
    end
    done = 1'b0; out = '0;
    vectors++; if (lat != 18 || res_gcd !== 8'd7 || res_timeout !== 1'b0) begin miscompares++; $display("FAIL tmo_done_wins: got lat=%0d gcd=%0d tmo=%b expected 18,7,0", lat, res_gcd, res_timeout); end
    release_result();
`else
    lat = -1;
    in_valid = 1'b1; in_x = 8'd20; in_y = 8'd30;
    step();
    in_valid = 1'b0;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      step();
      if (res_valid === 1'b1) lat = i;
    end
    vectors++; if (lat != -1) begin miscompares++; $display("FAIL notmo_stays_wait: got res_valid at %0d expected never", lat); end
    done = 1'b1; out = 8'd10;
    step();
    done = 1'b0; out = '0;
    vectors++; if (res_valid !== 1'b1 || res_gcd !== 8'd10 || res_timeout !== 1'b0) begin miscompares++; $display("FAIL notmo_late_done: got valid=%b gcd=%0d tmo=%b expected 1,10,0", res_valid, res_gcd, res_timeout); end
    release_result();
`endif
    vectors++; if (job_count !== 16'(exp_jobs)) begin miscompares++; $display("FAIL tmo_job_count: got %0d expected %0d", job_count, exp_jobs); end
  endtask

  task automatic test_reset_mid_job();
    in_valid = 1'b1; in_x = 8'd8; in_y = 8'd12;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b0;
    #1;
    exp_jobs = 0;
    vectors++; if (go !== 1'b0 || res_valid !== 1'b0 || in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_wait_outputs: got go=%b valid=%b ready=%b expected 0,0,0", go, res_valid, in_ready); end
    vectors++; if (job_count !== 16'd0 || x !== 8'd0) begin miscompares++; $display("FAIL rst_wait_regs: got count=%0d x=%0d expected 0,0", job_count, x); end
    step();
    rst = 1'b1;
    step();
    vectors++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_wait_release: got valid=%b ready=%b expected 0,1", res_valid, in_ready); end
    in_valid = 1'b1; in_x = 8'd3; in_y = 8'd6;
    step();
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    vectors++; if (go !== 1'b0) begin miscompares++; $display("FAIL rst_go_immediate: got %b expected 0", go); end
    step();
    rst = 1'b1;
    step();
    in_valid = 1'b1; in_x = 8'd21; in_y = 8'd14;
    step();
    in_valid = 1'b0;
    step(); step();
    done = 1'b1; out = 8'd7;
    step();
    done = 1'b0; out = '0;
    vectors++; if (res_valid !== 1'b1 || res_gcd !== 8'd7 || res_x !== 8'd21) begin miscompares++; $display("FAIL rst_next_job: got valid=%b gcd=%0d x=%0d expected 1,7,21", res_valid, res_gcd, res_x); end
    release_result();
    vectors++; if (job_count !== 16'(exp_jobs)) begin miscompares++; $display("FAIL rst_job_count: got %0d expected %0d", job_count, exp_jobs); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stale_done();
    test_zero_operand();
    test_back_pressure();
    test_timeout();
    test_reset_mid_job();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got simulation still running expected finish");
    $fatal(1, "time limit");
  end

endmodule
